// File: rtl/stepper_pkg.sv
// Shared types, phase table and phase-step helper for the stepper move sequencer.
package stepper_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Index 0 is the rightmost entry; odd indices drive two coils, even indices drive one.
  localparam logic [7:0][3:0] PhaseTable = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic logic [2:0] next_phase(input logic [2:0] phase, input logic dir,
                                            input logic half_step);
    logic [2:0] delta;
    delta = half_step ? 3'd1 : 3'd2;
    return dir ? phase + delta : phase - delta;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate divider: counts 0..period-1 and pulses tick on the last count, then reloads.
module step_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // period is never zero here; the controller maps 0 to 1 when latching.
  assign tick = en && !clr && (cnt_q == period - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr || tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Move sequencer: latches a move command and walks the coil phase table at the commanded rate.
module stepper_move_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic             half_step,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  output logic [3:0]       coils,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase
);

  import stepper_pkg::*;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [3:0]       coils_q;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic             step_pulse_q, busy_q, done_q;
  logic             step, tick, presc_clr;

  step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .clr    (presc_clr),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    dir_d       = dir_q;
    half_d      = half_q;
    step        = 1'b0;
    // Hold the divider at zero outside a move so each move starts from a full period.
    presc_clr   = (state_q != StRun) || abort;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (steps == '0) begin
            state_d = StDone;
          end else begin
            remaining_d = steps;
            dir_d       = dir;
            half_d      = half_step;
            period_d    = (period == '0) ? DIV_W'(1) : period;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          remaining_d = '0;
          state_d     = StIdle;
        end else if (tick) begin
          step        = 1'b1;
          phase_d     = next_phase(phase_q, dir_q, half_q);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      phase_q      <= 3'd0;
      coils_q      <= 4'b0001;
      remaining_q  <= '0;
      period_q     <= DIV_W'(1);
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      coils_q      <= PhaseTable[phase_d];
      remaining_q  <= remaining_d;
      period_q     <= period_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      step_pulse_q <= step;
      busy_q       <= (state_q == StRun) && !abort;
      done_q       <= (state_q == StDone);
    end else begin
      // Strobes must not stretch while frozen; everything else holds.
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end
  end

  assign coils      = coils_q;
  assign phase      = phase_q;
  assign step_pulse = step_pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl: expected strobes are queued at issue, checked by a monitor.
module tb_stepper_move_ctrl;

  localparam logic [3:0] Tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                     4'b0100, 4'b1100, 4'b1000, 4'b1001};

  typedef struct packed {
    logic       is_done;
    logic [2:0] ph;
    logic [3:0] coils;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, abort, dir, half_step;
  logic [15:0] steps, period;
  logic [3:0]  coils;
  logic        step_pulse, busy, done;
  logic [2:0]  phase;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          busy_cnt = 0;
  logic [2:0]  model_phase = 3'd0;

  stepper_move_ctrl #(
    .CNT_W (16),
    .DIV_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .abort      (abort),
    .dir        (dir),
    .half_step  (half_step),
    .steps      (steps),
    .period     (period),
    .coils      (coils),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done),
    .phase      (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [2:0] model_next(input logic [2:0] p, input logic d, input logic h);
    int v;
    v = int'(p) + (d ? 1 : -1) * (h ? 1 : 2);
    return 3'((v + 8) % 8);
  endfunction

  task automatic check_event(input logic is_done);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got strobe expected none (cycle %0d)",
               is_done ? "done" : "step", cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", is_done, e.is_done);
      chk("event_cycle", cyc, e.cyc);
      chk("event_phase", phase, e.ph);
      chk("event_coils", coils, e.coils);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (step_pulse) check_event(1'b0);
      if (done) check_event(1'b1);
    end
  end

  // Issue a move at the current negedge; pulses from index sk onward are delayed by sh cycles.
  task automatic move(input logic d, input logic h, input int n, input int p, input int npush,
                      input bit push_done, input int sk, input int sh);
    int   c0, peff, t;
    exp_t e;
    logic [2:0] ph;
    peff = (p == 0) ? 1 : p;
    c0 = cyc + 1;
    ph = model_phase;
    for (int k = 1; k <= npush; k++) begin
      ph = model_next(ph, d, h);
      t = c0 + k * peff + ((sk != 0 && k >= sk) ? sh : 0);
      e = '{is_done: 1'b0, ph: ph, coils: Tbl[ph], cyc: t};
      exp_q.push_back(e);
    end
    if (push_done) begin
      t = c0 + n * peff + 1 + ((sk != 0 && sk <= n) ? sh : 0);
      e = '{is_done: 1'b1, ph: ph, coils: Tbl[ph], cyc: t};
      exp_q.push_back(e);
    end
    model_phase = ph;
    busy_cnt  = 0;
    dir       = d;
    half_step = h;
    steps     = 16'(n);
    period    = 16'(p);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    // Scramble command inputs to show they were latched.
    dir       = ~d;
    half_step = ~h;
    steps     = 16'd7;
    period    = 16'd9;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    dir = 1'b0; half_step = 1'b0; steps = '0; period = '0;
    repeat (2) @(negedge clk);
    chk("rst_coils", coils, 4'b0001);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_pulse", step_pulse, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Half-step up, 10 steps of 4 cycles: 0 -> 2.
    move(1'b1, 1'b1, 10, 4, 10, 1'b1, 0, 0);
    drain(100);
    chk("m1_busy_cycles", busy_cnt, 40);
    chk("m1_phase", phase, 2);
    chk("m1_coils", coils, 4'b0010);

    // Full-step down, period 0 treated as 1: 2 -> 0 -> 6 -> 4.
    move(1'b0, 1'b0, 3, 0, 3, 1'b1, 0, 0);
    drain(50);
    chk("m2_busy_cycles", busy_cnt, 3);
    chk("m2_phase", phase, 4);
    chk("m2_coils", coils, 4'b0100);

    // Zero-step move: done only, no motion, busy never rises.
    move(1'b1, 1'b1, 0, 5, 0, 1'b1, 0, 0);
    drain(20);
    chk("m3_busy_cycles", busy_cnt, 0);
    chk("m3_phase", phase, 4);

    // 100-step move aborted after five pulses: 4 -> 1.
    move(1'b1, 1'b1, 100, 2, 5, 1'b0, 0, 0);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_phase", phase, 1);
    chk("abort_coils", coils, 4'b0011);
    repeat (30) @(negedge clk);
    chk("abort_no_more", exp_q.size(), 0);
    chk("abort_idle_busy", busy, 0);

    // Normal move after abort: 1 -> 3 -> 5.
    move(1'b1, 1'b0, 2, 1, 2, 1'b1, 0, 0);
    drain(30);
    chk("m5_phase", phase, 5);

    // ena low 7 cycles after first pulse: later pulses shift by 7. 5 -> 1.
    move(1'b0, 1'b1, 4, 3, 4, 1'b1, 2, 7);
    repeat (4) @(negedge clk);
    ena = 1'b0;
    repeat (7) @(negedge clk);
    ena = 1'b1;
    drain(60);
    chk("ena_phase", phase, 1);

    // start while busy is ignored: still 3 steps. 1 -> 4.
    move(1'b1, 1'b1, 3, 5, 3, 1'b1, 0, 0);
    repeat (6) @(negedge clk);
    start = 1'b1;
    steps = 16'd50;
    @(negedge clk);
    start = 1'b0;
    drain(60);
    chk("busy_start_phase", phase, 4);
    chk("busy_start_cycles", busy_cnt, 15);

    // Asynchronous reset mid-move, applied away from any clock edge. 4 -> 6 then reset.
    move(1'b1, 1'b1, 20, 3, 2, 1'b0, 0, 0);
    repeat (7) @(negedge clk);
    chk("pre_reset_phase", phase, 6);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_coils", coils, 4'b0001);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_phase", phase, 0);
    chk("async_rst_queue", exp_q.size(), 0);
    model_phase = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_phase", phase, 0);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
